orb_window_gen: RTL

//  Parametrised WINxWIN sliding-window generator for the ORB/BRIEF path.

---
 rtl/orb_window_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/orb_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : orb_window_gen
// Brief    : WINxWIN sliding-window generator for the ORB/BRIEF path, with
//            line buffers, optional zero-fill borders, window-valid flag and
//            window centre coordinates.
// Revision : 1.0
// ============================================================================
module orb_window_gen #(
    parameter  int PIX_W     = 8,
    parameter  int WIN       = 31,
    parameter  int IMG_W     = 640,
    parameter  int IMG_H     = 480,
    parameter  int ZERO_FILL = 1,
    localparam int CW        = $clog2(IMG_W),
    localparam int RW        = $clog2(IMG_H)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     image_vs_i,
    input  logic                     image_hs_i,
    input  logic                     image_en_i,
    input  logic [PIX_W-1:0]         pix_i,
    output logic                     image_vs_o,
    output logic                     image_hs_o,
    output logic                     image_en_o,
    output logic                     win_ok_o,
    output logic [WIN*WIN*PIX_W-1:0] win_o,
    output logic [CW-1:0]            ctr_x_o,
    output logic [RW-1:0]            ctr_y_o
);

    localparam logic [0:0]    c_idle     = 1'b0;
    localparam logic [0:0]    c_active   = 1'b1;
    localparam logic [CW-1:0] c_col_last = CW'(IMG_W - 1);
    localparam logic [RW-1:0] c_row_last = RW'(IMG_H - 1);
    localparam logic [CW-1:0] c_col_full = CW'(WIN - 1);
    localparam logic [RW-1:0] c_row_full = RW'(WIN - 1);
    localparam logic [CW-1:0] c_half_x   = CW'((WIN - 1) / 2);
    localparam logic [RW-1:0] c_half_y   = RW'((WIN - 1) / 2);

    logic [0:0]                     r_state;
    logic                           r_vs_d;
    logic [CW-1:0]                  r_col;
    logic [RW-1:0]                  r_row;
    // Only columns 1..WIN-1 of the last window are kept; column 0 is shifted out.
    logic [WIN*(WIN-1)*PIX_W-1:0]   r_sh;

    logic                           w_vs_rise;
    logic                           w_accept;
    logic [CW-1:0]                  w_col;
    logic [RW-1:0]                  w_row;
    logic [(WIN-1)*PIX_W-1:0]       w_lb_rd;
    logic [WIN*(WIN-1)*PIX_W-1:0]   w_sh_nxt;
    logic [WIN*WIN*PIX_W-1:0]       w_win_nxt;
    logic [WIN-1:0]                 w_rmask;
    logic [WIN-1:0]                 w_cmask;

    assign w_vs_rise = image_vs_i & ~r_vs_d;
    assign w_accept  = image_en_i & (r_state == c_active);
    // A frame-sync edge re-zeroes the counters before the coincident pixel uses them.
    assign w_col     = w_vs_rise ? '0 : r_col;
    assign w_row     = w_vs_rise ? '0 : r_row;

    // Line buffer k feeds tap row k; each write moves a pixel one row up.
    for (genvar k = 0; k < WIN - 1; k++) begin : g_lb
        logic [PIX_W-1:0] r_mem [IMG_W];
        logic [PIX_W-1:0] w_wdata;
        if (k == WIN - 2) begin : g_newest
            assign w_wdata = pix_i;
        end else begin : g_older
            assign w_wdata = w_lb_rd[(k+1)*PIX_W +: PIX_W];
        end
        always_ff @(posedge clk) begin
            if (w_accept) begin
                r_mem[w_col] <= w_wdata;
            end
        end
        assign w_lb_rd[k*PIX_W +: PIX_W] = r_mem[w_col];
    end

    for (genvar m = 0; m < WIN; m++) begin : g_mask
        if (ZERO_FILL != 0 && m < WIN - 1) begin : g_fill
            assign w_rmask[m] = (w_row < RW'(WIN - 1 - m));
            assign w_cmask[m] = (w_col < CW'(WIN - 1 - m));
        end else begin : g_pass
            assign w_rmask[m] = 1'b0;
            assign w_cmask[m] = 1'b0;
        end
    end

    for (genvar r = 0; r < WIN; r++) begin : g_row
        logic [PIX_W-1:0] w_in;
        if (r == WIN - 1) begin : g_pix
            assign w_in = pix_i;
        end else begin : g_buf
            assign w_in = w_lb_rd[r*PIX_W +: PIX_W];
        end
        for (genvar c = 0; c < WIN; c++) begin : g_col
            logic [PIX_W-1:0] w_tap;
            if (c == WIN - 1) begin : g_new
                assign w_tap = w_in;
            end else begin : g_old
                assign w_tap = r_sh[(r*(WIN-1)+c)*PIX_W +: PIX_W];
            end
            if (c > 0) begin : g_keep
                assign w_sh_nxt[(r*(WIN-1)+c-1)*PIX_W +: PIX_W] = w_tap;
            end
            assign w_win_nxt[(r*WIN+c)*PIX_W +: PIX_W] =
                (w_rmask[r] | w_cmask[c]) ? '0 : w_tap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_idle;
            r_vs_d     <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_sh       <= '0;
            image_vs_o <= 1'b0;
            image_hs_o <= 1'b0;
            image_en_o <= 1'b0;
            win_ok_o   <= 1'b0;
            win_o      <= '0;
            ctr_x_o    <= '0;
            ctr_y_o    <= '0;
        end else begin
            r_vs_d     <= image_vs_i;
            image_vs_o <= image_vs_i;
            image_hs_o <= image_hs_i;
            image_en_o <= w_accept;
            if (r_state == c_idle && w_vs_rise) begin
                r_state <= c_active;
            end
            if (w_accept) begin
                r_sh     <= w_sh_nxt;
                win_o    <= w_win_nxt;
                win_ok_o <= (w_row >= c_row_full) && (w_col >= c_col_full);
                ctr_x_o  <= w_col - c_half_x;
                ctr_y_o  <= w_row - c_half_y;
                if (w_col == c_col_last) begin
                    r_col <= '0;
                    r_row <= (w_row == c_row_last) ? '0 : w_row + RW'(1);
                end else begin
                    r_col <= w_col + CW'(1);
                    r_row <= w_row;
                end
            end else if (w_vs_rise) begin
                r_col <= '0;
                r_row <= '0;
            end
        end
    end

endmodule
`default_nettype wire
